// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the operand-select stage and the multiply/divide unit.
// The requester drives start/op/a/b; the unit returns status and the HI/LO result.
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, input busy, done, div_zero, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring on magnitudes) unit.
// One iteration per clock, WIDTH iterations per operation, HI/LO written on completion.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic             clk,
    input logic             reset,
    mult_div_unit_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             op_q;
    logic             dz_q;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic             q_1;
    logic [WIDTH-1:0] mcand;
    logic             busy_q;
    logic             done_q;
    logic             div_zero_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH:0]   mcand_x;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   acc_nx;
    logic [WIDTH-1:0] q_nx;
    logic [WIDTH-1:0] rem_mag;
    logic [WIDTH-1:0] hi_res;
    logic [WIDTH-1:0] lo_res;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // acc carries one guard bit so Booth add/sub of -2^(WIDTH-1) cannot overflow.
    always_comb begin
        mcand_x   = {mcand[WIDTH-1], mcand};
        booth_sum = acc;
        case ({q[0], q_1})
            2'b01:   booth_sum = acc + mcand_x;
            2'b10:   booth_sum = acc - mcand_x;
            default: booth_sum = acc;
        endcase
        trial = {acc[WIDTH-1:0], q[WIDTH-1]} - {1'b0, mcand};
        if (op_q) begin
            if (!trial[WIDTH]) begin
                acc_nx = {1'b0, trial[WIDTH-1:0]};
                q_nx   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_nx = {acc[WIDTH-1:0], q[WIDTH-1]};
                q_nx   = {q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nx = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            q_nx   = {booth_sum[0], q[WIDTH-1:1]};
        end
        rem_mag = acc[WIDTH-1:0];
        hi_res  = op_q ? (a_neg ? -rem_mag : rem_mag) : acc[WIDTH-1:0];
        lo_res  = op_q ? ((a_neg ^ b_neg) ? -q : q) : q;
        a_mag   = bus.a[WIDTH-1] ? -bus.a : bus.a;
        b_mag   = bus.b[WIDTH-1] ? -bus.b : bus.b;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            op_q       <= 1'b0;
            dz_q       <= 1'b0;
            a_neg      <= 1'b0;
            b_neg      <= 1'b0;
            acc        <= '0;
            q          <= '0;
            q_1        <= 1'b0;
            mcand      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= CALC;
                        busy_q <= 1'b1;
                        op_q   <= bus.op;
                        a_neg  <= bus.a[WIDTH-1];
                        b_neg  <= bus.b[WIDTH-1];
                        acc    <= '0;
                        q_1    <= 1'b0;
                        cnt    <= '0;
                        dz_q   <= 1'b0;
                        if (bus.op) begin
                            q     <= a_mag;
                            mcand <= b_mag;
                            // Divide by zero skips the iterations and goes straight to write-back.
                            if (bus.b == '0) begin
                                dz_q <= 1'b1;
                                cnt  <= CW'(WIDTH);
                            end
                        end else begin
                            q     <= bus.b;
                            mcand <= bus.a;
                        end
                    end
                end
                CALC: begin
                    if (cnt == CW'(WIDTH)) begin
                        state      <= FINISH;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        div_zero_q <= dz_q;
                        if (!dz_q) begin
                            hi_q <= hi_res;
                            lo_q <= lo_res;
                        end
                    end else begin
                        acc <= acc_nx;
                        q   <= q_nx;
                        q_1 <= q[0];
                        cnt <= cnt + 1'b1;
                    end
                end
                FINISH: begin
                    state      <= IDLE;
                    done_q     <= 1'b0;
                    div_zero_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Sequential signed multiply/divide unit, directly downstream of the ALU operand-select stage. Consumes the same 32-bit A and B operands the ALU sees and produces the 64-bit HI/LO result for MULT/DIV.
- The control FSM stalls on `busy` and uses `done` to advance to the HI/LO write-back step.
- One iteration per clock, 32 iterations per operation.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits. The iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  1  0 = MULT (signed), 1 = DIV (signed).
- a  input  WIDTH  multiplicand / dividend (register A).
- b  input  WIDTH  multiplier / divisor (register B).
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse when hi/lo hold the new result.
- div_zero  output  1  high together with `done` when a DIV had b == 0.
- hi  output  WIDTH  MULT: product[63:32]; DIV: remainder.
- lo  output  WIDTH  MULT: product[31:0]; DIV: quotient.

Behaviour:
- Reset (synchronous, active-high, clk):
  - state = IDLE; busy = 0, done = 0, div_zero = 0, hi = 0, lo = 0; iteration counter = 0.
  - Reset takes priority over everything and aborts any operation mid-flight with no partial write to hi/lo.
- State IDLE:
  - On an edge with start = 1, latch a, b and op into internal registers.
  - If op = 1 and b = 0, go to FINISH with the div-by-zero flag set.
  - Otherwise go to CALC with counter = 0.
  - busy is registered and goes to 1 after the start edge.
- State CALC:
  - Performs one iteration per edge, counter 0..31. After the 32nd iteration edge, go to FINISH.
  - Inputs a, b, op and start are ignored in CALC.
- MULT algorithm: radix-2 Booth on a {A_acc, Q, q-1} register.
  - The 64-bit result is the exact signed product, with no overflow.
  - Example: 0x80000000 × 0x80000000 = 0x40000000_00000000.
- DIV algorithm: restoring division on operand magnitudes, then sign fix-up.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Edge case: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (wraps; no exception).
- State FINISH, one cycle:
  - On the entry edge, hi/lo are written, done = 1, busy = 0 and div_zero is set.
  - On the next edge, done = 0, div_zero = 0 and state = IDLE.
  - A start in the FINISH cycle is ignored.
- Divide by zero: hi and lo keep their previous values; only done and div_zero pulse.
- Latency:
  - Start edge = edge 0; CALC iterations occur on edges 1..32; FINISH is entered on edge 33.
  - done is high in the cycle after edge 33. busy is high in the cycles after edges 0..32.
  - For divide by zero, done is high in the cycle after edge 1.
- Outputs: hi and lo are registered and hold until the next completed operation or reset. They are never modified during CALC.
- Start timing: a start while busy = 1 is dropped, not queued. Back-to-back operations are possible because start is accepted in the cycle following the done cycle.

Test Plan:
- Reset: assert reset for 2 cycles -> hi = 0, lo = 0, busy = 0, done = 0, div_zero = 0. Start held high during reset -> no operation begins.
- MULT 7 × -3 (a = 0x00000007, b = 0xFFFFFFFD) -> done high exactly in the cycle after edge 33; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; busy high for 33 cycles.
- MULT 0x80000000 × 0x80000000 -> hi = 0x40000000, lo = 0x00000000. Then MULT 0xFFFFFFFF × 0xFFFFFFFF -> hi = 0, lo = 1.
- DIV:
  - -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - 7 / -2 -> lo = 0xFFFFFFFD, hi = 0x00000001.
  - 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- DIV 5 / 0 after a MULT left hi = 0x12345678, lo = 0x9ABCDEF0 -> done and div_zero both high in the cycle after edge 1; hi and lo unchanged.
- Start a MULT; pulse start with new operands at cycle 10 -> ignored, result matches the first operands. Assert reset at cycle 20 of a second op -> busy = 0, hi/lo = 0 next cycle; a fresh MULT 3 × 4 then gives hi = 0, lo = 12 with normal latency.
